// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide sequencer.
// Holds the ALUControl encodings of the M-extension ops, the sequencer state
// enum and the op-class helpers. Build macro: MULDIV_DIV_EN enables the
// divider states; without it DIV-class codes are not treated as M-ops.
package muldiv_pkg;

    localparam logic [4:0] OpMul    = 5'b01010;
    localparam logic [4:0] OpMulh   = 5'b01011;
    localparam logic [4:0] OpMulhsu = 5'b01100;
    localparam logic [4:0] OpMulhu  = 5'b01101;
    localparam logic [4:0] OpDiv    = 5'b01110;
    localparam logic [4:0] OpDivu   = 5'b01111;
    localparam logic [4:0] OpRem    = 5'b10000;
    localparam logic [4:0] OpRemu   = 5'b10001;

`ifdef MULDIV_DIV_EN
    localparam bit DivEn = 1'b1;
`else
    localparam bit DivEn = 1'b0;
`endif

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StMul      = 3'd1,
`ifdef MULDIV_DIV_EN
        StDivSetup = 3'd2,
        StDivIter  = 3'd3,
        StDivFix   = 3'd4,
`endif
        StDone     = 3'd5
    } state_e;

    function automatic logic is_mul(input logic [4:0] op);
        return (op == OpMul) || (op == OpMulh) || (op == OpMulhsu) || (op == OpMulhu);
    endfunction

    function automatic logic is_div(input logic [4:0] op);
        return (op == OpDiv) || (op == OpDivu) || (op == OpRem) || (op == OpRemu);
    endfunction

    // Ops the sequencer accepts in this build.
    function automatic logic is_m_op(input logic [4:0] op);
        return is_mul(op) || (DivEn && is_div(op));
    endfunction

endpackage

// File: rtl/div_iter_unit.sv
// Restoring radix-2 divider datapath for unsigned operands.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   load              - load dividend/divisor, clear remainder, set counter to Width
//   step              - perform one shift-subtract step and decrement the counter
//   dividend, divisor - unsigned operands, sampled on load
//   quotient          - quotient register (complete after Width steps)
//   remainder         - partial remainder register
//   last              - counter is 1: the step taken this cycle is the final one
// Only compiled when MULDIV_DIV_EN is defined.
module div_iter_unit #(
    parameter int unsigned Width = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [Width-1:0] dividend,
    input  logic [Width-1:0] divisor,
    output logic [Width-1:0] quotient,
    output logic [Width-1:0] remainder,
    output logic             last
);

    localparam int unsigned CntW = $clog2(Width + 1);

    logic [Width-1:0] rem;
    logic [Width-1:0] quo;
    logic [Width-1:0] dvsr;
    logic [CntW-1:0]  count;
    logic [Width:0]   shifted;
    logic [Width:0]   diff;

    // Bring the next dividend bit into the partial remainder and trial-subtract.
    always_comb begin
        shifted = {rem, quo[Width-1]};
        diff    = shifted - {1'b0, dvsr};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem   <= '0;
            quo   <= '0;
            dvsr  <= '0;
            count <= '0;
        end else if (load) begin
            rem   <= '0;
            quo   <= dividend;
            dvsr  <= divisor;
            count <= CntW'(Width);
        end else if (step) begin
            // A negative trial result restores the shifted remainder; its MSB is
            // then known to be zero because it is below the divisor.
            if (!diff[Width]) begin
                rem <= diff[Width-1:0];
                quo <= {quo[Width-2:0], 1'b1};
            end else begin
                rem <= shifted[Width-1:0];
                quo <= {quo[Width-2:0], 1'b0};
            end
            count <= count - 1'b1;
        end
    end

    assign quotient  = quo;
    assign remainder = rem;
    assign last      = (count == CntW'(1));

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle M-extension controller at the E1/E2 boundary.
// Accepts one op from E1, runs it on a registered multiplier (result two cycles
// after accept) or, with MULDIV_DIV_EN defined, on the iterative divider
// (result 35 cycles after accept, or one cycle for divide-by-zero/overflow),
// stalling IF/D/E1 meanwhile and returning the result with its rd tag.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   start_i             - request, only honoured in IDLE
//   op_i                - ALUControl code
//   src_a_i, src_b_i    - forwarded rs1/rs2 values
//   rd_i                - destination tag
//   flush_i             - abort in-flight op, no result returned
//   stall_o             - hold the front of the pipeline
//   busy_o              - sequencer not in IDLE
//   done_o              - one-cycle result-valid pulse
//   result_o, rd_o      - result and tag, held after the pulse
// Build macro: MULDIV_DIV_EN (undefined: multiply only, DIV codes ignored).
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [4:0]      op_i,
    input  logic [XLEN-1:0] src_a_i,
    input  logic [XLEN-1:0] src_b_i,
    input  logic [4:0]      rd_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_o
);

    state_e          state;
    logic [4:0]      opcode;
    logic [XLEN-1:0] opa;
    logic [XLEN-1:0] opb;
    logic [4:0]      rd_lat;
    logic            accept_req;

    // ------------------------------------------------------------------
    // Multiplier: operands extended to XLEN+1 bits, then to the full
    // product width so the signed multiply is exact.
    // ------------------------------------------------------------------
    logic                   mul_sign_a;
    logic                   mul_sign_b;
    logic [XLEN:0]          mul_a;
    logic [XLEN:0]          mul_b;
    logic signed [2*XLEN+1:0] mul_prod;
    logic [XLEN-1:0]        mul_result;
    logic [1:0]             unused_mul_msbs;

    always_comb begin
        mul_sign_a = (opcode == OpMulh) || (opcode == OpMulhsu);
        mul_sign_b = (opcode == OpMulh);
        mul_a      = {mul_sign_a & opa[XLEN-1], opa};
        mul_b      = {mul_sign_b & opb[XLEN-1], opb};
        mul_prod   = $signed({{(XLEN+1){mul_a[XLEN]}}, mul_a})
                   * $signed({{(XLEN+1){mul_b[XLEN]}}, mul_b});
        mul_result = (opcode == OpMul) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];
    end

    assign unused_mul_msbs = mul_prod[2*XLEN+1:2*XLEN];

`ifdef MULDIV_DIV_EN
    // ------------------------------------------------------------------
    // Divider: special cases are resolved from the raw inputs at accept,
    // everything else goes through the magnitude divider and a sign fix.
    // ------------------------------------------------------------------
    localparam logic [XLEN-1:0] MinInt = {1'b1, {(XLEN-1){1'b0}}};

    logic            in_signed;
    logic            in_is_rem;
    logic            div_zero;
    logic            div_ovf;
    logic            div_special;
    logic [XLEN-1:0] special_result;
    logic            lat_signed;
    logic            lat_is_rem;
    logic [XLEN-1:0] abs_a;
    logic [XLEN-1:0] abs_b;
    logic            neg_quo;
    logic            neg_rem;
    logic [XLEN-1:0] div_quotient;
    logic [XLEN-1:0] div_remainder;
    logic            div_last;
    logic [XLEN-1:0] fix_result;

    always_comb begin
        in_signed      = (op_i == OpDiv) || (op_i == OpRem);
        in_is_rem      = (op_i == OpRem) || (op_i == OpRemu);
        div_zero       = (src_b_i == '0);
        div_ovf        = in_signed && (src_a_i == MinInt) && (src_b_i == '1);
        div_special    = div_zero || div_ovf;
        if (div_zero) begin
            special_result = in_is_rem ? src_a_i : '1;
        end else begin
            special_result = in_is_rem ? '0 : MinInt;
        end

        lat_signed = (opcode == OpDiv) || (opcode == OpRem);
        lat_is_rem = (opcode == OpRem) || (opcode == OpRemu);
        abs_a      = (lat_signed && opa[XLEN-1]) ? -opa : opa;
        abs_b      = (lat_signed && opb[XLEN-1]) ? -opb : opb;

        if (lat_is_rem) begin
            fix_result = neg_rem ? -div_remainder : div_remainder;
        end else begin
            fix_result = neg_quo ? -div_quotient : div_quotient;
        end
    end

    div_iter_unit #(
        .Width (XLEN)
    ) u_div_iter_unit (
        .clk       (clk),
        .rst       (rst),
        .load      (state == StDivSetup),
        .step      (state == StDivIter),
        .dividend  (abs_a),
        .divisor   (abs_b),
        .quotient  (div_quotient),
        .remainder (div_remainder),
        .last      (div_last)
    );
`endif

    assign accept_req = start_i && (state == StIdle) && is_m_op(op_i);

    // DONE releases the stall so the pipeline advances as the result retires.
    assign stall_o = accept_req || (busy_o && (state != StDone));

    // ------------------------------------------------------------------
    // Sequencer FSM with registered outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= StIdle;
            opcode   <= '0;
            opa      <= '0;
            opb      <= '0;
            rd_lat   <= '0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
            result_o <= '0;
            rd_o     <= '0;
`ifdef MULDIV_DIV_EN
            neg_quo  <= 1'b0;
            neg_rem  <= 1'b0;
`endif
        end else begin
            done_o <= 1'b0;
            if (flush_i) begin
                // Abort wins over a same-cycle request.
                state  <= StIdle;
                busy_o <= 1'b0;
            end else begin
                unique case (state)
                    StIdle: begin
                        if (accept_req) begin
                            opcode <= op_i;
                            opa    <= src_a_i;
                            opb    <= src_b_i;
                            rd_lat <= rd_i;
                            busy_o <= 1'b1;
`ifdef MULDIV_DIV_EN
                            if (is_div(op_i)) begin
                                if (div_special) begin
                                    result_o <= special_result;
                                    rd_o     <= rd_i;
                                    done_o   <= 1'b1;
                                    state    <= StDone;
                                end else begin
                                    state <= StDivSetup;
                                end
                            end else begin
                                state <= StMul;
                            end
`else
                            state <= StMul;
`endif
                        end
                    end
                    StMul: begin
                        result_o <= mul_result;
                        rd_o     <= rd_lat;
                        done_o   <= 1'b1;
                        state    <= StDone;
                    end
`ifdef MULDIV_DIV_EN
                    StDivSetup: begin
                        neg_quo <= lat_signed && (opa[XLEN-1] ^ opb[XLEN-1]);
                        neg_rem <= lat_signed && opa[XLEN-1];
                        state   <= StDivIter;
                    end
                    StDivIter: begin
                        if (div_last) begin
                            state <= StDivFix;
                        end
                    end
                    StDivFix: begin
                        result_o <= fix_result;
                        rd_o     <= rd_lat;
                        done_o   <= 1'b1;
                        state    <= StDone;
                    end
`endif
                    StDone: begin
                        state  <= StIdle;
                        busy_o <= 1'b0;
                    end
                    default: begin
                        state  <= StIdle;
                        busy_o <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;

    localparam logic [4:0] OpMul    = 5'b01010;
    localparam logic [4:0] OpMulh   = 5'b01011;
    localparam logic [4:0] OpMulhsu = 5'b01100;
    localparam logic [4:0] OpMulhu  = 5'b01101;
    localparam logic [4:0] OpDiv    = 5'b01110;
    localparam logic [4:0] OpDivu   = 5'b01111;
    localparam logic [4:0] OpRem    = 5'b10000;
    localparam logic [4:0] OpRemu   = 5'b10001;

`ifdef MULDIV_DIV_EN
    localparam bit DivOn = 1'b1;
`else
    localparam bit DivOn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [4:0]  op_i;
    logic [31:0] src_a_i;
    logic [31:0] src_b_i;
    logic [4:0]  rd_i;
    logic        flush_i;
    logic        stall_o;
    logic        busy_o;
    logic        done_o;
    logic [31:0] result_o;
    logic [4:0]  rd_o;

    int checks = 0;
    int errors = 0;

    muldiv_sequencer #(
        .XLEN (32)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start_i),
        .op_i     (op_i),
        .src_a_i  (src_a_i),
        .src_b_i  (src_b_i),
        .rd_i     (rd_i),
        .flush_i  (flush_i),
        .stall_o  (stall_o),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o),
        .rd_o     (rd_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] res;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string name, input logic [4:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic [4:0] rd,
                                input logic [31:0] res, input int lat);
        vec_t v;
        v.name = name; v.op = op; v.a = a; v.b = b; v.rd = rd; v.res = res; v.lat = lat;
        return v;
    endfunction

    // Reference: RISC-V M-extension semantics in plain 64-bit arithmetic.
    function automatic logic [31:0] ref_result(input logic [4:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        logic [63:0]     p;
        logic [31:0]     minv;
        logic [31:0]     ones;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        minv = 32'h8000_0000;
        ones = 32'hFFFF_FFFF;
        p = 64'h0;
        case (op)
            OpMul:    begin p = ua * ub; return p[31:0]; end
            OpMulh:   begin p = sa * sb; return p[63:32]; end
            OpMulhsu: begin p = sa * longint'(ub); return p[63:32]; end
            OpMulhu:  begin p = ua * ub; return p[63:32]; end
            OpDiv: begin
                if (b == 0) return ones;
                if (a == minv && b == ones) return minv;
                p = sa / sb; return p[31:0];
            end
            OpRem: begin
                if (b == 0) return a;
                if (a == minv && b == ones) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            OpDivu: begin
                if (b == 0) return ones;
                p = ua / ub; return p[31:0];
            end
            OpRemu: begin
                if (b == 0) return a;
                p = ua % ub; return p[31:0];
            end
            default: return 32'h0;
        endcase
    endfunction

    // Cycle of done_o counted from the accept cycle; 0 means not accepted.
    function automatic int ref_latency(input logic [4:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
        if (op == OpMul || op == OpMulh || op == OpMulhsu || op == OpMulhu) return 2;
        if (op == OpDiv || op == OpDivu || op == OpRem || op == OpRemu) begin
            if (!DivOn) return 0;
            if (b == 0) return 1;
            if ((op == OpDiv || op == OpRem) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                return 1;
            return 35;
        end
        return 0;
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request in the current cycle (cycle 0) and follow it to completion.
    task automatic run_vec(input string name, input logic [4:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] rd,
                           input logic [31:0] exp_res, input int exp_lat);
        int          lat;
        int          dones;
        int          bad_stall;
        int          bad_busy;
        int          last_k;
        logic [31:0] res;
        logic [4:0]  rdv;
        lat = 0; dones = 0; bad_stall = 0; bad_busy = 0; res = '0; rdv = '0;
        last_k = (exp_lat == 0) ? 4 : exp_lat + 1;
        start_i = 1'b1; op_i = op; src_a_i = a; src_b_i = b; rd_i = rd;
        @(negedge clk);
        check({name, ".stall0"}, 32'(stall_o), 32'(exp_lat != 0));
        tick();
        start_i = 1'b0;
        op_i = 5'($urandom); src_a_i = $urandom; src_b_i = $urandom; rd_i = 5'($urandom);
        for (int k = 1; k <= last_k; k++) begin
            @(negedge clk);
            if (done_o) begin
                dones++;
                if (lat == 0) begin lat = k; res = result_o; rdv = rd_o; end
            end
            if (exp_lat == 0) begin
                if (busy_o !== 1'b0 || stall_o !== 1'b0) bad_busy++;
            end else begin
                if (stall_o !== (k < exp_lat)) bad_stall++;
                if (busy_o !== (k <= exp_lat)) bad_busy++;
            end
            tick();
        end
        check({name, ".latency"}, 32'(lat), 32'(exp_lat));
        check({name, ".done_pulses"}, 32'(dones), 32'(exp_lat != 0));
        check({name, ".busy_profile"}, 32'(bad_busy), 32'h0);
        if (exp_lat != 0) begin
            check({name, ".stall_profile"}, 32'(bad_stall), 32'h0);
            check({name, ".result"}, res, exp_res);
            check({name, ".rd"}, 32'(rdv), 32'(rd));
        end
        for (int w = 0; w < 60 && busy_o; w++) tick();
    endtask

    // Abort an in-flight op with flush_i or rst, then issue a fresh request.
    task automatic abort_test(input bit use_rst);
        string       nm;
        logic [4:0]  op;
        int          fc;
        int          dones;
        nm = use_rst ? "abort_rst" : "abort_flush";
        op = DivOn ? OpDiv : OpMul;
        fc = DivOn ? 10 : 1;
        dones = 0;
        start_i = 1'b1; op_i = op; src_a_i = 32'hFFFF_FFF9; src_b_i = 32'h2; rd_i = 5'd20;
        tick();
        start_i = 1'b0;
        for (int c = 1; c <= fc; c++) begin
            if (c == fc) begin
                if (use_rst) rst = 1'b1;
                else flush_i = 1'b1;
            end
            @(negedge clk);
            if (done_o) dones++;
            tick();
        end
        rst = 1'b0;
        flush_i = 1'b0;
        check({nm, ".busy"}, 32'(busy_o), 32'h0);
        check({nm, ".done"}, 32'(done_o), 32'h0);
        check({nm, ".early_done"}, 32'(dones), 32'h0);
        if (use_rst) begin
            check({nm, ".stall"}, 32'(stall_o), 32'h0);
            check({nm, ".result"}, result_o, 32'h0);
            check({nm, ".rd"}, 32'(rd_o), 32'h0);
            run_vec("after_rst", OpMul, 32'd6, 32'd7, 5'd21, 32'd42, 2);
        end else begin
            run_vec("after_flush", OpMul, 32'd3, 32'd5, 5'd9, 32'd15, 2);
        end
    endtask

    task automatic back_to_back();
        logic [31:0] a_t[3];
        logic [31:0] b_t[3];
        logic [4:0]  rd_t[3];
        int          cyc[3];
        logic [31:0] res[3];
        logic [4:0]  rdv[3];
        int          n;
        a_t  = '{32'd7, 32'd100000, 32'hFFFF_FFFF};
        b_t  = '{32'd6, 32'd300000, 32'd3};
        rd_t = '{5'd1, 5'd2, 5'd31};
        n = 0;
        for (int i = 0; i < 3; i++) begin cyc[i] = -1; res[i] = '0; rdv[i] = '0; end
        for (int c = 0; c < 12; c++) begin
            if (c < 9) begin
                start_i = 1'b1; op_i = OpMul;
                src_a_i = a_t[c/3]; src_b_i = b_t[c/3]; rd_i = rd_t[c/3];
            end else begin
                start_i = 1'b0;
            end
            @(negedge clk);
            if (c == 3) check("b2b.stall_at_reaccept", 32'(stall_o), 32'h1);
            if (done_o) begin
                if (n < 3) begin cyc[n] = c; res[n] = result_o; rdv[n] = rd_o; end
                n++;
            end
            tick();
        end
        check("b2b.done_count", 32'(n), 32'd3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("b2b.op%0d.cycle", i), 32'(cyc[i]), 32'(3 * i + 2));
            check($sformatf("b2b.op%0d.result", i), res[i], ref_result(OpMul, a_t[i], b_t[i]));
            check($sformatf("b2b.op%0d.rd", i), 32'(rdv[i]), 32'(rd_t[i]));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d",
                 checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        logic [4:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [4:0]  ops[8];
        ops = '{OpMul, OpMulh, OpMulhsu, OpMulhu, OpDiv, OpDivu, OpRem, OpRemu};

        rst = 1'b1; start_i = 1'b0; flush_i = 1'b0;
        op_i = '0; src_a_i = '0; src_b_i = '0; rd_i = '0;
        repeat (3) tick();
        @(negedge clk);
        check("reset.stall", 32'(stall_o), 32'h0);
        check("reset.busy", 32'(busy_o), 32'h0);
        check("reset.done", 32'(done_o), 32'h0);
        check("reset.result", result_o, 32'h0);
        check("reset.rd", 32'(rd_o), 32'h0);
        tick();
        rst = 1'b0;
        tick();

        vecs.push_back(mk("mul_basic", OpMul, 32'd12345, 32'd6789, 5'd14, 32'h04FE_D79D, 2));
        vecs.push_back(mk("mulhu_ones", OpMulhu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,
                          32'hFFFF_FFFE, 2));
        vecs.push_back(mk("mulh_ones", OpMulh, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'h0, 2));
        vecs.push_back(mk("mulhsu_ones", OpMulhsu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5,
                          32'hFFFF_FFFF, 2));
        vecs.push_back(mk("mul_wrap", OpMul, 32'hFFFF_FFFF, 32'd2, 5'd6, 32'hFFFF_FFFE, 2));
        vecs.push_back(mk("div_neg", OpDiv, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFD,
                          DivOn ? 35 : 0));
        vecs.push_back(mk("rem_neg", OpRem, 32'hFFFF_FFF9, 32'd2, 5'd8, 32'hFFFF_FFFF,
                          DivOn ? 35 : 0));
        vecs.push_back(mk("divu_by0", OpDivu, 32'd100, 32'd0, 5'd9, 32'hFFFF_FFFF,
                          DivOn ? 1 : 0));
        vecs.push_back(mk("remu_by0", OpRemu, 32'd100, 32'd0, 5'd10, 32'd100, DivOn ? 1 : 0));
        vecs.push_back(mk("div_ovf", OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000,
                          DivOn ? 1 : 0));
        vecs.push_back(mk("rem_ovf", OpRem, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h0,
                          DivOn ? 1 : 0));
        vecs.push_back(mk("divu_basic", OpDivu, 32'd100, 32'd7, 5'd15, 32'd14, DivOn ? 35 : 0));
        vecs.push_back(mk("remu_basic", OpRemu, 32'd100, 32'd7, 5'd16, 32'd2, DivOn ? 35 : 0));
        vecs.push_back(mk("non_m_op", 5'b00000, 32'd5, 32'd6, 5'd13, 32'h0, 0));

        foreach (vecs[i]) begin
            run_vec(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd,
                    vecs[i].res, vecs[i].lat);
        end

        for (int i = 0; i < 50; i++) begin
            if ($urandom_range(0, 9) < 8) begin
                rop = ops[$urandom_range(0, 7)];
            end else begin
                rop = 5'($urandom);
                if (rop >= OpMul && rop <= OpRemu) rop = 5'b11111;
            end
            ra = rand_operand();
            rb = rand_operand();
            run_vec($sformatf("rand%0d", i), rop, ra, rb, 5'($urandom), ref_result(rop, ra, rb),
                    ref_latency(rop, ra, rb));
        end

        abort_test(1'b0);
        abort_test(1'b1);
        back_to_back();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
